// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default link constants,
// also used by the baud-rate generator.
package uart_pkg;

  localparam int DEF_NUM_TICKS = 16;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_SB_TICKS  = 16;
  localparam int BAUD_RATE     = 9600;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Larger of two integers, for sizing counters shared by several phases.
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to 1 so the
// idle-high line never looks like a start bit coming out of reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two register stages; the first may go metastable, the second settles it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit check at mid-bit, LSB-first data
// sampling at bit centres, stop-bit check with framing-error flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int SB_TICKS  = DEF_SB_TICKS,
  parameter int NUM_TICKS = DEF_NUM_TICKS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_tick,
  output logic [DATA_BITS-1:0] o_dout,
  output logic                 o_rx_done,
  output logic                 o_frame_err
);

  localparam int S_MAX = maxInt(NUM_TICKS, SB_TICKS);
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [S_W-1:0] S_HALF_LAST = S_W'(NUM_TICKS / 2 - 1);
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(NUM_TICKS - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_BITS - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [S_W-1:0]       r_s;
  logic [S_W-1:0]       w_s_next;
  logic [N_W-1:0]       r_n;
  logic [N_W-1:0]       w_n_next;
  logic [DATA_BITS-1:0] r_b;
  logic [DATA_BITS-1:0] w_b_next;
  logic                 r_rx_done;
  logic                 w_rx_done_next;
  logic                 r_frame_err;
  logic                 w_frame_err_next;
  logic                 w_rx_s;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

  // State, counters, shift register and the registered done/error flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_s         <= w_s_next;
      r_n         <= w_n_next;
      r_b         <= w_b_next;
      r_rx_done   <= w_rx_done_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  // Next-state logic; counters only move on TICK, except the idle start detect.
  always_comb begin
    w_state_next     = r_state;
    w_s_next         = r_s;
    w_n_next         = r_n;
    w_b_next         = r_b;
    w_rx_done_next   = 1'b0;
    w_frame_err_next = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_next = START;
          w_s_next     = '0;
        end
      end

      START: begin
        if (i_tick) begin
          if (r_s == S_HALF_LAST) begin
            if (!w_rx_s) begin
              w_state_next = DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_s_next = r_s + S_W'(1);
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s_next = '0;
            w_b_next = {w_rx_s, r_b[DATA_BITS-1:1]};
            if (r_n == N_LAST) begin
              w_state_next = STOP;
            end else begin
              w_n_next = r_n + N_W'(1);
            end
          end else begin
            w_s_next = r_s + S_W'(1);
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (r_s == S_STOP_LAST) begin
            w_state_next     = IDLE;
            w_rx_done_next   = 1'b1;
            w_frame_err_next = ~w_rx_s;
          end else begin
            w_s_next = r_s + S_W'(1);
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_dout      = r_b;
  assign o_rx_done   = r_rx_done;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised at 64 CLKs per bit with
// TICK every 4 CLKs; expected words are queued at send time and popped by a
// monitor on each RX_DONE pulse.
module tb_uart_rx;

  localparam int CLKS_PER_BIT = 64;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    int         stopStart;
  } exp_t;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       rx       = 1'b1;
  logic       tick     = 1'b0;
  logic       mirror   = 1'b0;
  logic       rx2;
  logic [7:0] dout;
  logic [7:0] dout2;
  logic       rxDone;
  logic       rxDone2;
  logic       frameErr;
  logic       frameErr2;

  int         cyc         = 0;
  int         checks      = 0;
  int         failures    = 0;
  int         lastDoneCyc = 0;
  int         done2Cyc    = 0;
  int         done2Count  = 0;
  logic [7:0] done2Data   = 8'h00;
  logic       done2Ferr   = 1'b0;
  logic       prevDone    = 1'b0;
  logic [7:0] modelDout   = 8'h00;
  exp_t       expQ[$];

  assign rx2 = mirror ? rx : 1'b1;

  uart_rx #(.DATA_BITS(8), .SB_TICKS(16), .NUM_TICKS(16)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rx        (rx),
    .i_tick      (tick),
    .o_dout      (dout),
    .o_rx_done   (rxDone),
    .o_frame_err (frameErr)
  );

  uart_rx #(.DATA_BITS(8), .SB_TICKS(32), .NUM_TICKS(16)) dut32 (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rx        (rx2),
    .i_tick      (tick),
    .o_dout      (dout2),
    .o_rx_done   (rxDone2),
    .o_frame_err (frameErr2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every RX_DONE pops the oldest expected frame.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   offset;
    if (rxDone) begin
      checkOutput("no_double_done", int'(prevDone), 0);
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got frame 0x%0h, expected no frame", dout);
      end else begin
        e = expQ.pop_front();
        checkOutput("dout", int'(dout), int'(e.data));
        checkOutput("frame_err", int'(frameErr), int'(e.ferr));
        offset = cyc - e.stopStart;
        checks++;
        if (offset < 24 || offset > 44) begin
          failures++;
          $display("[TB] FAIL done_timing: got %0d CLKs into stop bit, expected 24..44", offset);
        end
      end
      lastDoneCyc = cyc;
    end
    prevDone = rxDone;
  end

  always @(negedge clk) begin
    if (rxDone2) begin
      done2Cyc   = cyc;
      done2Count++;
      done2Data  = dout2;
      done2Ferr  = frameErr2;
    end
  end

  // Serialise one frame; resetBit >= 0 pulses RESET mid-way through that data bit.
  task automatic applyStimulus(input logic [7:0] data, input bit badStop, input int resetBit);
    exp_t e;
    int   startCyc;
    startCyc = cyc;
    if (resetBit < 0) begin
      e.data      = data;
      e.ferr      = badStop;
      e.stopStart = startCyc + 9 * CLKS_PER_BIT;
      expQ.push_back(e);
      modelDout = data;
    end
    rx = 1'b0;
    repeat (CLKS_PER_BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == resetBit) begin
        repeat (CLKS_PER_BIT / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        modelDout = 8'h00;
        checkOutput("midframe_reset_dout", int'(dout), 0);
        checkOutput("midframe_reset_done", int'(rxDone), 0);
        checkOutput("midframe_reset_ferr", int'(frameErr), 0);
        repeat (3 * CLKS_PER_BIT / 2) @(negedge clk);
        return;
      end
      repeat (CLKS_PER_BIT) @(negedge clk);
    end
    if (badStop) begin
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (80) @(negedge clk);
    end else begin
      rx = 1'b1;
      repeat (CLKS_PER_BIT) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] d;
    bit         bad;

    repeat (4) @(negedge clk);
    checkOutput("reset_dout", int'(dout), 0);
    checkOutput("reset_done", int'(rxDone), 0);
    checkOutput("reset_ferr", int'(frameErr), 0);
    checkOutput("reset_dout_sb32", int'(dout2), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    applyStimulus(8'h55, 1'b0, -1);
    repeat (40) @(negedge clk);

    applyStimulus(8'hA3, 1'b0, -1);
    applyStimulus(8'h0F, 1'b0, -1);
    repeat (40) @(negedge clk);

    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("glitch_dout_kept", int'(dout), int'(modelDout));
    checkOutput("glitch_no_pending", expQ.size(), 0);

    applyStimulus(8'hFF, 1'b1, -1);
    repeat (20) @(negedge clk);

    applyStimulus(8'h3C, 1'b0, 4);
    applyStimulus(8'h81, 1'b0, -1);
    repeat (40) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      applyStimulus(d, bad, -1);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end

    repeat (100) @(negedge clk);
    mirror = 1'b1;
    applyStimulus(8'h01, 1'b0, -1);
    mirror = 1'b0;
    for (int w = 0; w < 300 && done2Count == 0; w++) @(negedge clk);
    checkOutput("sb32_done_count", done2Count, 1);
    checkOutput("sb32_extra_latency", done2Cyc - lastDoneCyc, 64);
    checkOutput("sb32_dout", int'(done2Data), 8'h01);
    checkOutput("sb32_ferr", int'(done2Ferr), 0);

    for (int w = 0; w < 200 && expQ.size() != 0; w++) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, LSB first.
REQ-002 Parameter SB_TICKS, default 16: TICK count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter NUM_TICKS, default 16: TICKs per bit (oversampling factor).
REQ-004 CLK  input  1  system clock; all logic on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 RX  input  1  asynchronous serial line; idles high.
REQ-007 TICK  input  1  one-CLK pulse at NUM_TICKS x baud, from the baud-rate generator.
REQ-008 DOUT  output  DATA_BITS  last received data word.
REQ-009 RX_DONE  output  1  one-CLK pulse when a frame completes.
REQ-010 FRAME_ERR  output  1  valid only while RX_DONE=1; 1 = stop bit sampled low.

Function
REQ-011 RX SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value (rx_s).
REQ-012 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-013 The FSM SHALL use a tick counter s of width clog2(max(NUM_TICKS, SB_TICKS)).
REQ-014 The FSM SHALL use a bit counter n of width clog2(DATA_BITS).
REQ-015 The FSM SHALL use a shift register b of width DATA_BITS.
REQ-016 IDLE: on rx_s=0, the FSM SHALL go to START with s=0; TICK is not required for this transition.
REQ-017 START: on TICK with s=NUM_TICKS/2-1 and rx_s=0, the FSM SHALL go to DATA with s=0, n=0.
REQ-018 START: on TICK with s=NUM_TICKS/2-1 and rx_s=1 (glitch), the FSM SHALL return to IDLE with no RX_DONE.
REQ-019 START: on any other TICK, s SHALL increment.
REQ-020 DATA: on TICK with s=NUM_TICKS-1, the FSM SHALL set s=0 and shift b right with rx_s entering the MSB.
REQ-021 DATA: after that shift, if n=DATA_BITS-1 the FSM SHALL go to STOP, else n SHALL increment.
REQ-022 DATA: on any other TICK, s SHALL increment.
REQ-023 STOP: on TICK with s=SB_TICKS-1, the FSM SHALL go to IDLE and assert RX_DONE for exactly that CLK.
REQ-024 STOP: in that same CLK, FRAME_ERR SHALL be set to NOT rx_s.
REQ-025 STOP: on any other TICK, s SHALL increment.
REQ-026 In any state, cycles with TICK=0 SHALL leave s, n and b unchanged, except for the IDLE->START transition.
REQ-027 DOUT SHALL equal b continuously; it SHALL be stable from RX_DONE until the next DATA shift.
REQ-028 DOUT SHALL be updated even when FRAME_ERR=1.
REQ-029 RX_DONE and FRAME_ERR SHALL be registered outputs.
REQ-030 RX_DONE SHALL never be high for two consecutive CLKs.
REQ-031 Latency: RX_DONE SHALL rise on the CLK after the TICK that completes the stop-bit count.
REQ-032 A new falling edge on rx_s in the cycle IDLE is re-entered SHALL be accepted on the next CLK; back-to-back frames SHALL NOT be lost.
REQ-033 Counter wrap: s and n SHALL never exceed their terminal values.
REQ-034 TICK held high continuously SHALL be treated as one tick per CLK.

Reset
REQ-035 RESET=1 SHALL force, on the next CLK edge: state=IDLE, s=0, n=0, b=0, DOUT=0, RX_DONE=0, FRAME_ERR=0.
REQ-036 RESET=1 SHALL force both synchronizer flops to 1 on the next CLK edge.
REQ-037 RESET asserted mid-frame SHALL abort the frame silently; no RX_DONE SHALL occur for the aborted frame.
REQ-038 After RESET deasserts, reception SHALL resume at the next falling edge of rx_s.
REQ-039 RESET SHALL take priority over TICK and RX.

Structure
REQ-040 Shared package uart_pkg SHALL hold the state enumeration (IDLE, START, DATA, STOP).
REQ-041 uart_pkg SHALL hold the default NUM_TICKS=16, DATA_BITS=8, SB_TICKS=16 and BAUD_RATE=9600 constants, shared with the baud generator.
REQ-042 The synchronizer SHALL be one sub-module, sync_2ff: CLK, RESET, D, Q, with reset value 1.
REQ-043 All remaining logic SHALL reside in uart_rx as a single FSM with registered outputs.

Verification (bench drives TICK every 4 CLKs; 1 bit = 64 CLKs)
REQ-044 Frame 0x55, valid stop bit -> one RX_DONE pulse, DOUT=0x55, FRAME_ERR=0.
REQ-045 Frames 0xA3 then 0x0F back-to-back with no idle gap -> two RX_DONE pulses, DOUT=0xA3 then 0x0F, FRAME_ERR=0 on both.
REQ-046 RX low for 16 CLKs (4 ticks) then high -> return to IDLE, no RX_DONE, DOUT unchanged.
REQ-047 Frame 0xFF with stop bit held low -> RX_DONE=1 with FRAME_ERR=1, DOUT=0xFF.
REQ-048 RESET pulsed during data bit 4 of frame 0x3C, then frame 0x81 -> no pulse for 0x3C; one RX_DONE with DOUT=0x81.
REQ-049 SB_TICKS=32, frame 0x01 -> RX_DONE occurs 64 CLKs later than with SB_TICKS=16.
